// File: rtl/serial_mag_comparator.sv
// Bit-serial A-vs-B magnitude comparator. Results appear one cycle after the completing beat.
// There is no backpressure: every beat with in_valid is taken, and idle beats are ignored.
module serial_mag_comparator #(
    parameter int MAX_BITS  = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic                           in_first,
    input  logic                           in_last,
    input  logic                           a,
    input  logic                           b,
    output logic                           out_valid,
    output logic                           equal,
    output logic                           greater,
    output logic                           lesser,
    output logic [$clog2(MAX_BITS+1)-1:0]  bit_count,
    output logic                           err
);

    localparam int CW = $clog2(MAX_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BITS);

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          gt_q, lt_q, gt_n, lt_n;
    logic          done, ovf;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gt_n    = gt_q;
        lt_n    = lt_q;
        done    = 1'b0;
        ovf     = 1'b0;
        if (in_valid) begin
            if (in_first) begin
                cnt_n = CW'(1);
                gt_n  = a & ~b;
                lt_n  = ~a & b;
                if (in_last) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = COMPARE;
                end
            end else if (state == COMPARE) begin
                if (cnt == CNT_MAX) begin
                    ovf     = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                    gt_n    = 1'b0;
                    lt_n    = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                    // MSB-first locks on the first difference; LSB-first lets the latest difference win
                    if ((a != b) && ((MSB_FIRST == 0) || !(gt_q || lt_q))) begin
                        gt_n = a;
                        lt_n = b;
                    end
                    if (in_last) begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            equal     <= 1'b0;
            greater   <= 1'b0;
            lesser    <= 1'b0;
            bit_count <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            gt_q      <= gt_n;
            lt_q      <= lt_n;
            out_valid <= done;
            err       <= ovf;
            if (done) begin
                equal     <= ~(gt_n | lt_n);
                greater   <= gt_n;
                lesser    <= lt_n;
                bit_count <= cnt_n;
            end
        end
    end

endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 SHALL have parameter MAX_BITS, default 16, meaning the maximum operand length in bits per frame (legal range 1..64).
REQ-002 SHALL have parameter MSB_FIRST, default 1, where 1 means bits arrive most-significant first and 0 means least-significant first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the current a/b bit pair is presented.
REQ-006 SHALL have port in_first, input, 1 bit: the beat is the first bit of a frame; qualified by in_valid.
REQ-007 SHALL have port in_last, input, 1 bit: the beat is the last bit of a frame; qualified by in_valid.
REQ-008 SHALL have ports a and b, input, 1 bit each: the operand bits for this beat.
REQ-009 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new result.
REQ-010 SHALL have ports equal, greater and lesser, output, 1 bit each, registered: the frame result, where greater means A>B and lesser means A<B.
REQ-011 SHALL have port bit_count, output, $clog2(MAX_BITS+1) bits: the number of bits in the last completed frame.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse on frame overflow.

Function
REQ-013 SHALL implement states IDLE and COMPARE, held in a registered state variable.
REQ-014 IDLE: beats with in_valid=1 and in_first=0 SHALL be ignored with no output change.
REQ-015 A beat with in_valid and in_first accepted in any state SHALL start a new frame: clear the internal flags, set the bit counter to 1, evaluate the bit, and enter COMPARE.
REQ-016 in_first during COMPARE SHALL abandon the prior frame silently (no out_valid, no err).
REQ-017 Each accepted beat SHALL increment the internal bit counter by 1.
REQ-018 Beats with in_valid=0 SHALL not advance state or the counter, so gaps of any length are legal.
REQ-019 With MSB_FIRST=1, the first differing bit SHALL fix the result; later bits SHALL not change it.
REQ-020 With MSB_FIRST=0, each differing bit SHALL overwrite the result with its own relation (a=1,b=0 gives greater; a=0,b=1 gives lesser).
REQ-021 Equal bits SHALL leave the result unchanged, and the default result is equal.
REQ-022 A beat with in_last accepted in COMPARE, or in_first and in_last together, SHALL complete the frame.
REQ-023 On frame completion, in the next cycle:
- out_valid=1 for exactly one cycle;
- equal, greater and lesser updated, with exactly one of them high;
- bit_count set to the frame length;
- state returns to IDLE.
REQ-024 equal, greater, lesser and bit_count SHALL hold their values until the next completed frame.
REQ-025 The completing beat's bit SHALL be included in the result, so latency is 1 cycle from the last-bit beat to out_valid.
REQ-026 A frame completing with in_first and in_last on the same beat SHALL produce the result of a 1-bit compare of a and b.
REQ-027 Overflow is an accepted beat in COMPARE, without in_first, while the counter already equals MAX_BITS. On overflow the block SHALL:
- pulse err high for one cycle;
- discard the frame without asserting out_valid;
- leave the result outputs unchanged;
- return to IDLE.
REQ-028 A frame of exactly MAX_BITS bits whose last beat carries in_last SHALL complete normally with no err.
REQ-029 out_valid and err SHALL never be high in the same cycle.
REQ-030 A new in_first beat in the same cycle that out_valid is high SHALL be accepted, allowing back-to-back frames with no idle cycle.

Reset
REQ-031 Asserting rst_n low SHALL immediately and asynchronously force all of the following, regardless of clk:
- state to IDLE and the internal counter and flags to 0;
- out_valid, err, equal, greater and lesser to 0;
- bit_count to 0.
REQ-032 Reset asserted mid-frame SHALL discard the frame, and no out_valid SHALL follow release.
REQ-033 After rst_n returns high, the first accepted beat SHALL require in_first.

Verification
REQ-034 SHALL cover: defaults, MSB-first, 4-bit frame A=1010, B=1001 -> out_valid 1 cycle after last beat; greater=1, equal=0, lesser=0, bit_count=4.
REQ-035 SHALL cover: MSB_FIRST=0, A=0110, B=0101 sent LSB-first -> greater=1; then A=B=0011 -> equal=1, bit_count=4.
REQ-036 SHALL cover: all four 1-bit frames (in_first=in_last=1) with ab=00,01,10,11 -> equal, lesser, greater, equal respectively.
REQ-037 SHALL cover: MAX_BITS=4, five beats with no in_last -> err pulse on the cycle after the 5th beat, no out_valid, previous result held.
REQ-038 SHALL cover: in_valid gaps of 3 cycles between beats of a 3-bit frame A=011, B=011 -> equal=1, bit_count=3; then back-to-back frame A=0, B=1 -> lesser=1 on the next out_valid.
REQ-039 SHALL cover: rst_n low after 2 beats of a 4-bit frame -> all outputs 0 asynchronously; remaining beats without in_first ignored; no out_valid.
